rv_fpu_dispatch_arb: RTL and testbench
======================================

// Module: rv_fpu_dispatch_arb
// PURPOSE
//  Parametrised dispatch/collect fabric for the FPU cluster, with NUM_CORES functional units (FMA/CVT/NCP/...).
//  Routes each request's handshake to the unit picked by core_sel and caps in-flight ops per unit.
//  Merges unit results through a round-robin arbiter into one registered output stage.
//  Keeps a sticky, lane-ORed fflags accumulator for the CSR block. Operand data is broadcast to the units outside this block.
// PARAMETERS
//  NUM_CORES    3  number of FP functional units (>=2)
//  LANES        4  threads per request (= `NUM_THREADS)
//  TAGW         2  tag width
//  MAX_PENDING  4  max in-flight ops per unit (>=1); CNTW = $clog2(MAX_PENDING+1)
//  CSW          $clog2(NUM_CORES)  core_sel width
// PORTS
//  clk             in   1                 clock, rising edge
//  reset           in   1                 asynchronous, active-high
//  valid_in        in   1                 request valid
//  ready_in        out  1                 request accepted when valid_in&&ready_in
//  core_sel        in   CSW               target unit, from rv_fpu_pkg core map
//  unit_valid_in   out  NUM_CORES         one-hot valid to units
//  unit_ready_in   in   NUM_CORES         unit input ready
//  unit_valid_out  in   NUM_CORES         unit result valid
//  unit_ready_out  out  NUM_CORES         one-hot result accept
//  unit_result     in   NUM_CORES*LANES*32  unit results, unit i at [i*LANES*32 +: LANES*32]
//  unit_tag        in   NUM_CORES*TAGW    unit tags
//  unit_has_fflags in   NUM_CORES         unit result carries flags
//  unit_fflags     in   NUM_CORES*LANES*5 per-lane {NV,DZ,OF,UF,NX}
//  valid_out/ready_out  out/in 1          merged result handshake
//  result          out  LANES*32          merged result
//  tag_out         out  TAGW              merged tag
//  has_fflags      out  1                 merged has_fflags
//  fflags          out  LANES*5           merged per-lane flags
//  fflags_acc      out  5                 sticky OR of accepted flags
//  fflags_clr      in   1                 clear fflags_acc
//  illegal_op      out  1                 1-cycle pulse: request dropped, core_sel>=NUM_CORES
//  busy            out  1                 any pending count !=0, or valid_out
// BEHAVIOUR
//  Reset values: valid_out=0, result/tag_out/fflags/has_fflags=0, fflags_acc=0, illegal_op=0, all pending=0, rr_ptr=0.
//  Dispatch (combinational):
//   - unit_valid_in[s] = valid_in && s==core_sel && pending[s]<MAX_PENDING.
//   - ready_in = unit_ready_in[core_sel] && pending[core_sel]<MAX_PENDING.
//   - core_sel>=NUM_CORES: ready_in=1, no unit_valid_in; illegal_op registered high next cycle.
//  pending[i]:
//   - +1 on unit i input fire; -1 on unit i output fire; both in the same cycle -> unchanged.
//   - Never wraps. A return fire at pending=0 is a protocol error: SVA assert, counter holds 0.
//  Collect:
//   - Output register loads when !valid_out || ready_out.
//   - Grant g = first i with unit_valid_out[i], scanning from rr_ptr upward modulo NUM_CORES.
//   - unit_ready_out[g]=1 only when the register loads; that is the unit output fire.
//   - rr_ptr <= (g+1)%NUM_CORES on fire; unchanged otherwise.
//   - Latency: unit_valid_out -> valid_out is 1 cycle. Full throughput: 1 result/cycle with ready_out held high.
//   - valid_out held, payload stable while ready_out=0. Drops to 0 after fire if no unit is valid.
//  fflags_acc:
//   - On output fire with has_fflags: acc |= OR over lanes of fflags.
//   - fflags_clr and fire in the same cycle: acc = new flags only (clear first, then set).
//  Reset mid-operation: all in-flight ops are forgotten. Units are reset by the same signal.
// STRUCTURE
//  rv_fpu_pkg holds:
//   - FFLAG_* bit indices (NV=4..NX=0)
//   - FPU_CORE_FMA/CVT/NCP constants
//   - function fpu_core_of(op_type) -> core index (ADD/SUB/MUL/MADD/MSUB/NMADD/NMSUB->FMA, CVTxx->CVT, else NCP)
//  Sub-module rv_rr_arbiter #(N): request vector, enable -> one-hot grant + index, internal pointer.
//  Pending counters are a generate loop in this file.
// TESTING
//  1. Reset mid-burst: assert reset with pending!=0 and valid_out=1 -> next cycle all outputs 0, busy=0.
//  2. MAX_PENDING=4, unit1 never returns, core_sel=1 x5 -> 4 accepted, 5th sees ready_in=0.
//     Then one unit1 return -> 5th accepted.
//  3. Units 0,1,2 all valid continuously, ready_out=1 -> grants 0,1,2,0,... one per cycle; tags match sources.
//  4. ready_out=0 for 3 cycles with valid_out=1 -> result/tag stable, unit_ready_out=0;
//     release -> fire, next grant follows the rr order.
//  5. Lane flags NV then NX on two fires, fflags_clr on the second -> fflags_acc=5'b10000 then 5'b00001.
//  6. core_sel=3 with NUM_CORES=3 -> ready_in=1, unit_valid_in=0, illegal_op=1 for exactly one cycle.

Source files
------------

// File: rtl/rv_fpu_pkg.sv
// rv_fpu_pkg: FPU flag bit indices, functional-unit map and op-to-unit helper.
package rv_fpu_pkg;
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    localparam int FPU_CORE_FMA = 0;
    localparam int FPU_CORE_CVT = 1;
    localparam int FPU_CORE_NCP = 2;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_MADD, OP_MSUB, OP_NMADD, OP_NMSUB,
        OP_CVTWS, OP_CVTWUS, OP_CVTSW, OP_CVTSWU,
        OP_DIV, OP_SQRT, OP_CMP, OP_MINMAX, OP_SGNJ
    } fpu_op_e;

    function automatic logic [1:0] fpu_core_of(input fpu_op_e op);
        return (op inside {OP_ADD, OP_SUB, OP_MUL, OP_MADD, OP_MSUB, OP_NMADD, OP_NMSUB}) ? 2'(FPU_CORE_FMA) :
               (op inside {OP_CVTWS, OP_CVTWUS, OP_CVTSW, OP_CVTSWU}) ? 2'(FPU_CORE_CVT) : 2'(FPU_CORE_NCP);
    endfunction
endpackage

// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: grants the first request at or after the pointer; pointer moves past the winner when enabled.
module rv_rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req,
    input  logic                 i_en,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_j;

    // Scan from the far end so the last hit written is the closest to the pointer.
    always_comb begin
        o_idx = r_ptr;
        o_any = 1'b0;
        w_j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = IW'((int'(r_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_idx = w_j;
                o_any = 1'b1;
            end
        end
    end

    assign o_grant = (i_en && o_any) ? N'(1) << o_idx : '0;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_ptr <= '0;
        else if (i_en && o_any) r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/rv_fpu_dispatch_arb.sv
// rv_fpu_dispatch_arb: steers requests to the selected FPU unit with per-unit in-flight caps,
// merges unit results round-robin into one output register and accumulates sticky fflags.
module rv_fpu_dispatch_arb
    import rv_fpu_pkg::*;
#(
    parameter  int NUM_CORES   = 3,
    parameter  int LANES       = 4,
    parameter  int TAGW        = 2,
    parameter  int MAX_PENDING = 4,
    localparam int CSW         = $clog2(NUM_CORES),
    localparam int CNTW        = $clog2(MAX_PENDING + 1),
    localparam int FLAGW       = FFLAG_NV + 1
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_valid_in,
    output logic                               o_ready_in,
    input  logic [CSW-1:0]                     i_core_sel,
    output logic [NUM_CORES-1:0]               o_unit_valid_in,
    input  logic [NUM_CORES-1:0]               i_unit_ready_in,
    input  logic [NUM_CORES-1:0]               i_unit_valid_out,
    output logic [NUM_CORES-1:0]               o_unit_ready_out,
    input  logic [NUM_CORES*LANES*32-1:0]      i_unit_result,
    input  logic [NUM_CORES*TAGW-1:0]          i_unit_tag,
    input  logic [NUM_CORES-1:0]               i_unit_has_fflags,
    input  logic [NUM_CORES*LANES*FLAGW-1:0]   i_unit_fflags,
    output logic                               o_valid_out,
    input  logic                               i_ready_out,
    output logic [LANES*32-1:0]                o_result,
    output logic [TAGW-1:0]                    o_tag_out,
    output logic                               o_has_fflags,
    output logic [LANES*FLAGW-1:0]             o_fflags,
    output logic [FLAGW-1:0]                   o_fflags_acc,
    input  logic                               i_fflags_clr,
    output logic                               o_illegal_op,
    output logic                               o_busy
);
    logic [NUM_CORES-1:0]     w_sel, w_room, w_busy_u, w_in_fire;
    logic                     w_legal, w_load, w_fire, w_gany;
    logic [CSW-1:0]           w_gidx;
    logic [FLAGW-1:0]         w_lane_or;
    logic                     r_valid, r_has, r_illegal;
    logic [LANES*32-1:0]      r_result;
    logic [TAGW-1:0]          r_tag;
    logic [LANES*FLAGW-1:0]   r_fflags;
    logic [FLAGW-1:0]         r_acc;

    assign o_unit_valid_in = {NUM_CORES{i_valid_in}} & w_sel & w_room;
    assign w_in_fire = o_unit_valid_in & i_unit_ready_in;
    assign w_legal = |w_sel;
    assign o_ready_in = !w_legal || |(w_sel & i_unit_ready_in & w_room);

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unit
        logic [CNTW-1:0] r_pend;
        assign w_sel[g] = i_core_sel == CSW'(g);
        assign w_room[g] = r_pend < CNTW'(MAX_PENDING);
        assign w_busy_u[g] = r_pend != '0;
        always_ff @(posedge i_clk or posedge i_reset)
            if (i_reset) r_pend <= '0;
            else if (w_in_fire[g] && !o_unit_ready_out[g]) r_pend <= r_pend + 1'b1;
            else if (o_unit_ready_out[g] && !w_in_fire[g] && w_busy_u[g]) r_pend <= r_pend - 1'b1;
        a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset) !(o_unit_ready_out[g] && !w_busy_u[g]));
    end

    assign w_load = !r_valid || i_ready_out;
    assign w_fire = r_valid && i_ready_out;

    rv_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_req   (i_unit_valid_out),
        .i_en    (w_load),
        .o_grant (o_unit_ready_out),
        .o_idx   (w_gidx),
        .o_any   (w_gany)
    );

    always_comb begin
        w_lane_or = '0;
        for (int l = 0; l < LANES; l++) w_lane_or |= r_fflags[l*FLAGW +: FLAGW];
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
            r_has     <= 1'b0;
            r_fflags  <= '0;
            r_acc     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= i_valid_in && !w_legal;
            // Clear takes effect before the flags of a coinciding fire are merged in.
            r_acc <= (i_fflags_clr ? '0 : r_acc) | ((w_fire && r_has) ? w_lane_or : '0);
            if (w_load) r_valid <= w_gany;
            if (w_load && w_gany) begin
                r_result <= i_unit_result[int'(w_gidx)*LANES*32 +: LANES*32];
                r_tag    <= i_unit_tag[int'(w_gidx)*TAGW +: TAGW];
                r_has    <= i_unit_has_fflags[w_gidx];
                r_fflags <= i_unit_fflags[int'(w_gidx)*LANES*FLAGW +: LANES*FLAGW];
            end
        end

    assign o_valid_out  = r_valid;
    assign o_result     = r_result;
    assign o_tag_out    = r_tag;
    assign o_has_fflags = r_has;
    assign o_fflags     = r_fflags;
    assign o_fflags_acc = r_acc;
    assign o_illegal_op = r_illegal;
    assign o_busy       = |w_busy_u || r_valid;
endmodule

// File: tb/tb_rv_fpu_dispatch_arb.sv
// tb_rv_fpu_dispatch_arb: directed scenarios for dispatch caps, round-robin collect,
// backpressure, fflags accumulation, illegal core_sel and reset.
module tb_rv_fpu_dispatch_arb;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic [1:0]   core_sel = '0;
    logic [2:0]   unit_valid_in;
    logic [2:0]   unit_ready_in = 3'b111;
    logic [2:0]   unit_valid_out = '0;
    logic [2:0]   unit_ready_out;
    logic [383:0] unit_result = '0;
    logic [5:0]   unit_tag = '0;
    logic [2:0]   unit_has_fflags = '0;
    logic [59:0]  unit_fflags = '0;
    logic         valid_out;
    logic         ready_out = 1'b0;
    logic [127:0] result;
    logic [1:0]   tag_out;
    logic         has_fflags;
    logic [19:0]  fflags;
    logic [4:0]   fflags_acc;
    logic         fflags_clr = 1'b0;
    logic         illegal_op;
    logic         busy;
    int           n_checks = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    rv_fpu_dispatch_arb dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_valid_in       (valid_in),
        .o_ready_in       (ready_in),
        .i_core_sel       (core_sel),
        .o_unit_valid_in  (unit_valid_in),
        .i_unit_ready_in  (unit_ready_in),
        .i_unit_valid_out (unit_valid_out),
        .o_unit_ready_out (unit_ready_out),
        .i_unit_result    (unit_result),
        .i_unit_tag       (unit_tag),
        .i_unit_has_fflags(unit_has_fflags),
        .i_unit_fflags    (unit_fflags),
        .o_valid_out      (valid_out),
        .i_ready_out      (ready_out),
        .o_result         (result),
        .o_tag_out        (tag_out),
        .o_has_fflags     (has_fflags),
        .o_fflags         (fflags),
        .o_fflags_acc     (fflags_acc),
        .i_fflags_clr     (fflags_clr),
        .o_illegal_op     (illegal_op),
        .o_busy           (busy)
    );

    function automatic logic [127:0] exp_res(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input int s);
        valid_in = 1'b1;
        core_sel = 2'(s);
        step();
        valid_in = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid_out: got %b exp 0", valid_out); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_checks++; if (fflags_acc !== 5'b0) begin n_err++; $display("FAIL rst_acc: got %b exp 0", fflags_acc); end
        n_checks++; if (illegal_op !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b exp 0", illegal_op); end
        n_checks++; if (result !== 128'b0 || tag_out !== 2'b0) begin n_err++; $display("FAIL rst_payload: got %h/%h exp 0/0", result, tag_out); end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_pending_cap;
        valid_in = 1'b1;
        core_sel = 2'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (ready_in !== 1'b1 || unit_valid_in !== 3'b010) begin n_err++; $display("FAIL cap_accept[%0d]: got %b/%b exp 1/010", k, ready_in, unit_valid_in); end
            step();
        end
        #1;
        n_checks++; if (ready_in !== 1'b0 || unit_valid_in !== 3'b000) begin n_err++; $display("FAIL cap_full: got %b/%b exp 0/000", ready_in, unit_valid_in); end
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL cap_busy: got %b exp 1", busy); end
        unit_valid_out = 3'b010;
        ready_out = 1'b1;
        #1;
        n_checks++; if (unit_ready_out !== 3'b010 || ready_in !== 1'b0) begin n_err++; $display("FAIL cap_return: got %b/%b exp 010/0", unit_ready_out, ready_in); end
        step();
        unit_valid_out = 3'b000;
        #1;
        n_checks++; if (ready_in !== 1'b1 || unit_valid_in !== 3'b010) begin n_err++; $display("FAIL cap_fifth: got %b/%b exp 1/010", ready_in, unit_valid_in); end
        n_checks++; if (valid_out !== 1'b1 || tag_out !== 2'd2) begin n_err++; $display("FAIL cap_out: got %b/%0d exp 1/2", valid_out, tag_out); end
        step();
        valid_in = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL cap_drain: got %b exp 0", valid_out); end
    endtask

    task automatic test_reset_mid_burst;
        ready_out = 1'b0;
        unit_valid_out = 3'b010;
        step();
        unit_valid_out = 3'b000;
        #1;
        n_checks++; if (valid_out !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %b/%b exp 1/1", valid_out, busy); end
        reset = 1'b1;
        #1;
        n_checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst: got %b/%b exp 0/0", valid_out, busy); end
        n_checks++; if (result !== 128'b0 || tag_out !== 2'b0 || fflags !== 20'b0 || has_fflags !== 1'b0) begin n_err++; $display("FAIL mid_payload: got %h/%h/%h/%b exp zeros", result, tag_out, fflags, has_fflags); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_round_robin;
        ready_out = 1'b1;
        for (int k = 0; k < 6; k++) dispatch(k % 3);
        unit_valid_out = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++; if (unit_ready_out !== 3'(1 << (k % 3))) begin n_err++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, unit_ready_out, 3'(1 << (k % 3))); end
            step();
            if (k == 5) unit_valid_out = 3'b000;
            #1;
            n_checks++; if (valid_out !== 1'b1 || tag_out !== 2'(k % 3 + 1) || result !== exp_res(k % 3)) begin n_err++; $display("FAIL rr_out[%0d]: got %b/%0d/%h exp 1/%0d/%h", k, valid_out, tag_out, result, k % 3 + 1, exp_res(k % 3)); end
        end
        step();
        n_checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: got %b/%b exp 0/0", valid_out, busy); end
    endtask

    task automatic test_backpressure;
        dispatch(0);
        dispatch(0);
        dispatch(1);
        ready_out = 1'b0;
        unit_valid_out = 3'b011;
        #1;
        n_checks++; if (unit_ready_out !== 3'b001) begin n_err++; $display("FAIL bp_first: got %b exp 001", unit_ready_out); end
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (unit_ready_out !== 3'b000 || valid_out !== 1'b1 || tag_out !== 2'd1 || result !== exp_res(0)) begin n_err++; $display("FAIL bp_hold[%0d]: got %b/%b/%0d/%h exp 000/1/1/%h", k, unit_ready_out, valid_out, tag_out, result, exp_res(0)); end
            step();
        end
        ready_out = 1'b1;
        #1;
        n_checks++; if (unit_ready_out !== 3'b010) begin n_err++; $display("FAIL bp_release: got %b exp 010", unit_ready_out); end
        step();
        unit_valid_out = 3'b001;
        #1;
        n_checks++; if (tag_out !== 2'd2 || unit_ready_out !== 3'b001) begin n_err++; $display("FAIL bp_next: got %0d/%b exp 2/001", tag_out, unit_ready_out); end
        step();
        unit_valid_out = 3'b000;
        #1;
        n_checks++; if (valid_out !== 1'b1 || tag_out !== 2'd1) begin n_err++; $display("FAIL bp_last: got %b/%0d exp 1/1", valid_out, tag_out); end
        step();
        n_checks++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b exp 0", valid_out); end
    endtask

    task automatic test_fflags;
        dispatch(2);
        dispatch(2);
        unit_has_fflags = 3'b100;
        unit_fflags = '0;
        unit_fflags[50 +: 5] = 5'b10000;
        unit_valid_out = 3'b100;
        ready_out = 1'b1;
        step();
        unit_fflags = '0;
        unit_fflags[40 +: 5] = 5'b00001;
        #1;
        n_checks++; if (has_fflags !== 1'b1 || fflags !== 20'h04000 || fflags_acc !== 5'b0) begin n_err++; $display("FAIL ff_first: got %b/%h/%b exp 1/04000/00000", has_fflags, fflags, fflags_acc); end
        step();
        unit_valid_out = 3'b000;
        fflags_clr = 1'b1;
        #1;
        n_checks++; if (fflags_acc !== 5'b10000 || fflags !== 20'h00001) begin n_err++; $display("FAIL ff_nv: got %b/%h exp 10000/00001", fflags_acc, fflags); end
        step();
        fflags_clr = 1'b0;
        #1;
        n_checks++; if (fflags_acc !== 5'b00001 || valid_out !== 1'b0) begin n_err++; $display("FAIL ff_clr: got %b/%b exp 00001/0", fflags_acc, valid_out); end
        step();
        n_checks++; if (fflags_acc !== 5'b00001) begin n_err++; $display("FAIL ff_sticky: got %b exp 00001", fflags_acc); end
        unit_has_fflags = 3'b000;
    endtask

    task automatic test_illegal;
        valid_in = 1'b1;
        core_sel = 2'd3;
        #1;
        n_checks++; if (ready_in !== 1'b1 || unit_valid_in !== 3'b000 || illegal_op !== 1'b0) begin n_err++; $display("FAIL ill_comb: got %b/%b/%b exp 1/000/0", ready_in, unit_valid_in, illegal_op); end
        step();
        valid_in = 1'b0;
        #1;
        n_checks++; if (illegal_op !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ill_pulse: got %b/%b exp 1/0", illegal_op, busy); end
        step();
        n_checks++; if (illegal_op !== 1'b0) begin n_err++; $display("FAIL ill_end: got %b exp 0", illegal_op); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            unit_result[i*128 +: 128] = exp_res(i);
            unit_tag[i*2 +: 2] = 2'(i + 1);
        end
        test_reset();
        test_pending_cap();
        test_reset_mid_burst();
        test_round_robin();
        test_backpressure();
        test_fflags();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
